// File: rtl/hb_dispatch_pkg.sv
// Shared constants and the round-robin bank picker for the bank dispatcher.
package hb_dispatch_pkg;

    localparam int unsigned MODE_RR   = 32'd0;
    localparam int unsigned MODE_ADDR = 32'd1;
    localparam int unsigned MAX_BANKS = 32'd32;
    localparam int unsigned MAX_BW    = 32'd5;

    // Index of the first non-full bank at or after ptr, wrapping modulo num_banks.
    // Falls back to ptr when every bank is full; the caller gates on in_ready.
    function automatic int unsigned rr_pick(
        input logic [MAX_BANKS-1:0] full_vec,
        input int unsigned          ptr,
        input int unsigned          num_banks
    );
        int unsigned      pick;
        logic             found;
        logic [MAX_BW-1:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_BANKS; i++) begin
            idx = MAX_BW'((ptr + i) & (num_banks - 32'd1));
            if (!found && (i < num_banks) && !full_vec[idx]) begin
                pick  = {27'd0, idx};
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/hb_bank_fifo.sv
// Single-bank FIFO with occupancy counter; head is shown combinationally.
module hb_bank_fifo
    import hb_dispatch_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output logic              full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push_s;
    logic              do_pop_s;

    // Qualify handshakes and compute next pointers/occupancy.
    always_comb begin
        do_push_s = push & (count_q != FULL_CNT);
        do_pop_s  = pop & (count_q != '0);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents of free slots are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hb_bank_dispatcher.sv
// Steers a ready/valid word stream into NUM_BANKS per-bank FIFOs, either
// round-robin over non-full banks or decoded from an address field of the data.
module hb_bank_dispatcher
    import hb_dispatch_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 0,
    parameter int BANK_LSB   = 2,
    localparam int BW        = $clog2(NUM_BANKS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic [NUM_BANKS-1:0]          bank_valid,
    input  logic [NUM_BANKS-1:0]          bank_ready,
    output logic [NUM_BANKS*DATA_W-1:0]   bank_data,
    output logic [NUM_BANKS-1:0]          bank_full,
    output logic [NUM_BANKS-1:0]          grant_out,
    output logic [BW-1:0]                 served_bank,
    output logic [31:0]                   accept_cnt
);

    logic [NUM_BANKS-1:0] bank_full_s;
    logic [NUM_BANKS-1:0] bank_valid_s;
    logic [NUM_BANKS-1:0] push_vec_s;
    logic [MAX_BANKS-1:0] full_pad_s;
    logic [BW-1:0]        sel_s;
    logic                 in_ready_s;
    logic                 accept_s;

    logic [BW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_BANKS-1:0] grant_q, grant_d;
    logic [BW-1:0]        served_q, served_d;
    logic [31:0]          cnt_q, cnt_d;

    // Bank selection and input acceptance; uses only registered fullness.
    always_comb begin
        full_pad_s                  = '0;
        full_pad_s[NUM_BANKS-1:0]   = bank_full_s;
        if (MODE == MODE_ADDR) begin
            sel_s      = in_data[BANK_LSB +: BW];
            in_ready_s = ~bank_full_s[sel_s];
        end else begin
            sel_s      = BW'(rr_pick(full_pad_s, 32'(rr_ptr_q), NUM_BANKS));
            in_ready_s = ~(&bank_full_s);
        end
        accept_s   = in_valid & in_ready_s;
        push_vec_s = '0;
        if (accept_s) begin
            push_vec_s[sel_s] = 1'b1;
        end else begin
            push_vec_s = '0;
        end
    end

    // Next-state for pointer, grant pulse, served index and accept counter.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        served_d = served_q;
        cnt_d    = cnt_q;
        grant_d  = push_vec_s;
        if (accept_s) begin
            rr_ptr_d = sel_s + BW'(1);
            served_d = sel_s;
            cnt_d    = cnt_q + 32'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Dispatcher state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            served_q <= '0;
            cnt_q    <= 32'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            served_q <= served_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        hb_bank_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push_vec_s[g]),
            .push_data (in_data),
            .pop       (bank_ready[g]),
            .valid     (bank_valid_s[g]),
            .head      (bank_data[g*DATA_W +: DATA_W]),
            .full      (bank_full_s[g])
        );
    end

    assign in_ready    = in_ready_s;
    assign bank_valid  = bank_valid_s;
    assign bank_full   = bank_full_s;
    assign grant_out   = grant_q;
    assign served_bank = served_q;
    assign accept_cnt  = cnt_q;

endmodule

// File: tb/tb_hb_bank_dispatcher.sv
// Directed bench: one dispatcher in round-robin mode, one in address-decoded mode.
module tb_hb_bank_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic         rr_reset_n, rr_in_valid, rr_in_ready;
    logic [31:0]  rr_in_data, rr_cnt;
    logic [3:0]   rr_bank_valid, rr_bank_ready, rr_bank_full, rr_grant;
    logic [127:0] rr_bank_data;
    logic [1:0]   rr_served;

    logic         ad_reset_n, ad_in_valid, ad_in_ready;
    logic [31:0]  ad_in_data, ad_cnt;
    logic [3:0]   ad_bank_valid, ad_bank_ready, ad_bank_full, ad_grant;
    logic [127:0] ad_bank_data;
    logic [1:0]   ad_served;

    hb_bank_dispatcher #(.NUM_BANKS(4), .DATA_W(32), .FIFO_DEPTH(4), .MODE(0), .BANK_LSB(2)) u_dut_rr (
        .clk(clk), .reset_n(rr_reset_n), .in_valid(rr_in_valid), .in_ready(rr_in_ready),
        .in_data(rr_in_data), .bank_valid(rr_bank_valid), .bank_ready(rr_bank_ready),
        .bank_data(rr_bank_data), .bank_full(rr_bank_full), .grant_out(rr_grant),
        .served_bank(rr_served), .accept_cnt(rr_cnt)
    );

    hb_bank_dispatcher #(.NUM_BANKS(4), .DATA_W(32), .FIFO_DEPTH(4), .MODE(1), .BANK_LSB(2)) u_dut_ad (
        .clk(clk), .reset_n(ad_reset_n), .in_valid(ad_in_valid), .in_ready(ad_in_ready),
        .in_data(ad_in_data), .bank_valid(ad_bank_valid), .bank_ready(ad_bank_ready),
        .bank_data(ad_bank_data), .bank_full(ad_bank_full), .grant_out(ad_grant),
        .served_bank(ad_served), .accept_cnt(ad_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] rr_head(input int b);
        return rr_bank_data[b*32 +: 32];
    endfunction

    function automatic logic [31:0] ad_head(input int b);
        return ad_bank_data[b*32 +: 32];
    endfunction

    task automatic reset_rr();
        rr_in_valid = 1'b0;
        rr_bank_ready = 4'b0000;
        rr_reset_n = 1'b0;
        tick();
        rr_reset_n = 1'b1;
    endtask

    task automatic reset_ad();
        ad_in_valid = 1'b0;
        ad_bank_ready = 4'b0000;
        ad_reset_n = 1'b0;
        tick();
        ad_reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_grant;
        int occ;
        int pop_idx;

        rr_in_data = 32'd0;
        ad_in_data = 32'd0;
        reset_rr();
        reset_ad();
        settle();

        // Reset state
        check_eq("rst_valid", 32'(rr_bank_valid), 32'h0);
        check_eq("rst_full", 32'(rr_bank_full), 32'h0);
        check_eq("rst_grant", 32'(rr_grant), 32'h0);
        check_eq("rst_served", 32'(rr_served), 32'h0);
        check_eq("rst_cnt", rr_cnt, 32'h0);
        check_eq("rst_ready", 32'(rr_in_ready), 32'h1);
        check_eq("rst_ad_valid", 32'(ad_bank_valid), 32'h0);

        // MODE 0: six back-to-back words, no pops
        for (int k = 0; k < 6; k++) begin
            rr_in_valid = 1'b1;
            rr_in_data  = 32'hA0 + 32'(k);
            settle();
            check_eq("t1_ready", 32'(rr_in_ready), 32'h1);
            tick();
            exp_grant = 4'b0001 << (k % 4);
            check_eq("t1_grant", 32'(rr_grant), 32'(exp_grant));
        end
        rr_in_valid = 1'b0;
        tick();
        check_eq("t1_grant_idle", 32'(rr_grant), 32'h0);
        check_eq("t1_cnt", rr_cnt, 32'd6);
        check_eq("t1_served", 32'(rr_served), 32'd1);
        check_eq("t1_valid", 32'(rr_bank_valid), 32'hF);
        for (int b = 0; b < 4; b++) begin
            check_eq("t1_head", rr_head(b), 32'hA0 + 32'(b));
        end

        // MODE 0 skip-full: fill bank 1 while banks 0,2,3 drain
        reset_rr();
        rr_bank_ready = 4'b1101;
        for (int k = 0; k < 17; k++) begin
            rr_in_valid = 1'b1;
            rr_in_data  = 32'h100 + 32'(k);
            tick();
        end
        rr_in_valid = 1'b0;
        rr_bank_ready = 4'b0000;
        settle();
        check_eq("t2_full", 32'(rr_bank_full), 32'h2);
        check_eq("t2_valid", 32'(rr_bank_valid), 32'h3);
        check_eq("t2_head1", rr_head(1), 32'h101);
        check_eq("t2_cnt", rr_cnt, 32'd17);
        rr_in_valid = 1'b1;
        rr_in_data  = 32'h200;
        settle();
        check_eq("t2_ready", 32'(rr_in_ready), 32'h1);
        tick();
        check_eq("t2_grant", 32'(rr_grant), 32'h4);
        check_eq("t2_served", 32'(rr_served), 32'd2);
        for (int j = 0; j < 10; j++) begin
            rr_in_data = 32'h300 + 32'(j);
            settle();
            check_eq("t2_fill_ready", 32'(rr_in_ready), 32'h1);
            tick();
        end
        settle();
        check_eq("t2_allfull_ready", 32'(rr_in_ready), 32'h0);
        check_eq("t2_allfull", 32'(rr_bank_full), 32'hF);
        tick();
        check_eq("t2_stall_cnt", rr_cnt, 32'd28);
        check_eq("t2_stall_grant", 32'(rr_grant), 32'h0);
        rr_in_valid = 1'b0;

        // Reset mid-operation: three words parked in bank 2
        reset_rr();
        rr_bank_ready = 4'b1011;
        for (int k = 0; k < 11; k++) begin
            rr_in_valid = 1'b1;
            rr_in_data  = 32'h200 + 32'(k);
            tick();
        end
        rr_in_valid = 1'b0;
        rr_bank_ready = 4'b0000;
        settle();
        check_eq("t5_pre_valid", 32'(rr_bank_valid), 32'h4);
        check_eq("t5_pre_head2", rr_head(2), 32'h202);
        check_eq("t5_pre_cnt", rr_cnt, 32'd11);
        reset_rr();
        settle();
        check_eq("t5_valid", 32'(rr_bank_valid), 32'h0);
        check_eq("t5_full", 32'(rr_bank_full), 32'h0);
        check_eq("t5_cnt", rr_cnt, 32'h0);
        check_eq("t5_grant", 32'(rr_grant), 32'h0);
        check_eq("t5_served", 32'(rr_served), 32'h0);
        rr_in_valid = 1'b1;
        rr_in_data  = 32'h55;
        tick();
        rr_in_valid = 1'b0;
        check_eq("t5_grant_after", 32'(rr_grant), 32'h1);
        check_eq("t5_head0", rr_head(0), 32'h55);

        // MODE 1 decode and head-of-line stall
        settle();
        check_eq("t3_rst_valid", 32'(ad_bank_valid), 32'h0);
        ad_in_valid = 1'b1;
        ad_in_data  = 32'h0000_000C;
        settle();
        check_eq("t3_ready", 32'(ad_in_ready), 32'h1);
        tick();
        check_eq("t3_grant", 32'(ad_grant), 32'h8);
        check_eq("t3_served", 32'(ad_served), 32'd3);
        for (int k = 1; k < 4; k++) begin
            ad_in_data = 32'h00C + (32'(k) << 8);
            tick();
        end
        ad_in_data = 32'h40C;
        settle();
        check_eq("t3_full_ready", 32'(ad_in_ready), 32'h0);
        check_eq("t3_full", 32'(ad_bank_full), 32'h8);
        tick();
        check_eq("t3_stall_cnt", ad_cnt, 32'd4);
        check_eq("t3_stall_grant", 32'(ad_grant), 32'h0);
        ad_in_data = 32'h04;
        settle();
        check_eq("t3_switch_ready", 32'(ad_in_ready), 32'h1);
        tick();
        check_eq("t3_switch_grant", 32'(ad_grant), 32'h2);
        check_eq("t3_switch_served", 32'(ad_served), 32'd1);
        ad_in_valid = 1'b0;
        settle();
        check_eq("t3_valid", 32'(ad_bank_valid), 32'hA);
        check_eq("t3_head1", ad_head(1), 32'h04);
        check_eq("t3_head3", ad_head(3), 32'h0C);

        // Full bank 0 with simultaneous pop: no bypass
        reset_ad();
        for (int k = 0; k < 4; k++) begin
            ad_in_valid = 1'b1;
            ad_in_data  = 32'(k) << 8;
            tick();
        end
        ad_in_data = 32'h400;
        ad_bank_ready = 4'b0001;
        settle();
        check_eq("t4_ready_full", 32'(ad_in_ready), 32'h0);
        check_eq("t4_head_pre", ad_head(0), 32'h000);
        tick();
        check_eq("t4_cnt_nopush", ad_cnt, 32'd4);
        check_eq("t4_grant_nopush", 32'(ad_grant), 32'h0);
        check_eq("t4_full_after_pop", 32'(ad_bank_full), 32'h0);
        ad_bank_ready = 4'b0000;
        settle();
        check_eq("t4_ready_after", 32'(ad_in_ready), 32'h1);
        tick();
        check_eq("t4_grant", 32'(ad_grant), 32'h1);
        check_eq("t4_cnt", ad_cnt, 32'd5);
        check_eq("t4_full_again", 32'(ad_bank_full), 32'h1);
        ad_in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ad_bank_ready = 4'b0001;
            settle();
            check_eq("t4_drain_valid", 32'(ad_bank_valid[0]), 32'h1);
            check_eq("t4_drain_head", ad_head(0), 32'(j + 1) << 8);
            tick();
        end
        ad_bank_ready = 4'b0000;
        settle();
        check_eq("t4_empty", 32'(ad_bank_valid), 32'h0);

        // Wrap: ten words through bank 2 with concurrent push/pop
        reset_ad();
        occ = 0;
        pop_idx = 0;
        for (int k = 0; k < 10; k++) begin
            ad_in_valid   = 1'b1;
            ad_in_data    = 32'h008 + (32'(k) << 4);
            ad_bank_ready = (k >= 2) ? 4'b0100 : 4'b0000;
            settle();
            check_eq("t6_valid", 32'(ad_bank_valid[2]), 32'(occ > 0));
            check_eq("t6_full", 32'(ad_bank_full[2]), 32'h0);
            check_eq("t6_ready", 32'(ad_in_ready), 32'h1);
            if (ad_bank_ready[2] && occ > 0) begin
                check_eq("t6_order", ad_head(2), 32'h008 + (32'(pop_idx) << 4));
                pop_idx++;
                occ--;
            end
            occ++;
            tick();
        end
        ad_in_valid   = 1'b0;
        ad_bank_ready = 4'b0100;
        for (int g = 0; g < 8 && occ > 0; g++) begin
            settle();
            check_eq("t6_drain_valid", 32'(ad_bank_valid[2]), 32'h1);
            check_eq("t6_drain_order", ad_head(2), 32'h008 + (32'(pop_idx) << 4));
            check_eq("t6_drain_full", 32'(ad_bank_full[2]), 32'h0);
            pop_idx++;
            occ--;
            tick();
        end
        ad_bank_ready = 4'b0000;
        settle();
        check_eq("t6_empty", 32'(ad_bank_valid), 32'h0);
        check_eq("t6_popped", 32'(pop_idx), 32'd10);
        check_eq("t6_cnt", ad_cnt, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
